game_timer_bank: RTL and testbench

- Parametrised successor to the single two-second counter.
- Provides CHANNELS independent timeout timers, each with a runtime-loadable limit, clocked entirely from clk_50M.
- A shared internal prescaler replaces the separate 2 kHz clock.
- Sits between the debounced button inputs and the BlackJack game FSM: delivers dealer-delay and display-hold timeouts, plus an optional free-running seed counter for card shuffling.

---
 rtl/game_timer_pkg.sv | 38 +++
 rtl/tick_prescaler.sv | 55 +++++
 rtl/game_timer_bank.sv | 189 ++++++++++++++++++
 tb/tb_game_timer_bank.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// ---------------------------------------------------------------------------
// game_timer_pkg
//
// Shared definitions for the game timer bank:
//   - timer_state_e : per-channel state encoding (IDLE/RUN/DONE). The fourth
//                     code 2'd3 is never produced by the logic; if it ever
//                     appears, the channel falls back to IDLE.
//   - chan_dbg_t    : per-channel observation record (state + done strobe).
//                     The output decode reads it, so it is always present in
//                     the netlist and reachable hierarchically.
//   - calc_div / calc_presc_width : prescaler ratio and the counter width
//                     that holds 0..DIV-1.
// ---------------------------------------------------------------------------
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

  typedef struct packed {
    timer_state_e state;
    logic         done_pulse;
  } chan_dbg_t;

  // Clock cycles per timer tick. The caller must pick CLK_HZ/TICK_HZ so that
  // this divides exactly and is at least 2.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Bits needed to count 0..DIV-1.
  function automatic int calc_presc_width(input int clk_hz, input int tick_hz);
    return $clog2(calc_div(clk_hz, tick_hz));
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
//
// Free-running divider that turns clk_50M into a one-cycle tick strobe every
// DIV = CLK_HZ/TICK_HZ cycles. The internal counter runs 0..DIV-1 and wraps;
// o_Tick is high exactly in the cycle the counter holds DIV-1. No channel
// input affects it.
//
// Parameters:
//   CLK_HZ  - system clock frequency
//   TICK_HZ - tick rate (CLK_HZ/TICK_HZ must be an integer >= 2)
// Ports:
//   clk_50M - system clock
//   i_Reset - synchronous, active-high reset (counter and strobe to 0)
//   o_Tick  - registered tick strobe
// ---------------------------------------------------------------------------
module tick_prescaler
  import game_timer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 2000
) (
  input  logic clk_50M,
  input  logic i_Reset,
  output logic o_Tick
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = calc_presc_width(CLK_HZ, TICK_HZ);

  localparam logic [PW-1:0] LAST     = PW'(DIV - 1);
  // The strobe is a flop, so it is set while the counter is one step short
  // of LAST; it then coincides with the counter holding LAST.
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 2);

  logic [PW-1:0] presc_q;
  logic          tick_q;

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      if (presc_q == LAST) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      tick_q <= (presc_q == PRE_LAST);
    end
  end

  assign o_Tick = tick_q;

endmodule

// File: rtl/game_timer_bank.sv
// ---------------------------------------------------------------------------
// game_timer_bank
//
// CHANNELS independent timeout timers sharing one tick prescaler, all in the
// clk_50M domain. Each channel latches its limit on start, counts ticks while
// in RUN, and parks in DONE with the count held at the limit.
//
// Channel event priority (per channel c):
//   i_Reset > i_Zero[c] > i_Start[c] > tick
//
// Handshake/strobe semantics: there is no valid/ready pair here. i_Start and
// i_Zero are level-sampled every clock and act at the next edge; o_DonePulse
// is a one-cycle strobe on entry to DONE, o_Done is the matching level.
//
// Parameters:
//   CLK_HZ, TICK_HZ - prescaler ratio DIV = CLK_HZ/TICK_HZ (integer >= 2)
//   WIDTH           - bits per count, per limit, and of the seed
//   CHANNELS        - number of timers (>= 1)
// Ports:
//   clk_50M      in   system clock
//   i_Reset      in   synchronous active-high reset
//   i_Start      in   [CHANNELS]        start/restart strobe per channel
//   i_Zero       in   [CHANNELS]        synchronous clear per channel
//   i_Limit      in   [CHANNELS*WIDTH]  limit in ticks, slice c*WIDTH +: WIDTH
//   i_SeedRun    in   seed counter enable
//   o_Count      out  [CHANNELS*WIDTH]  elapsed ticks per channel
//   o_Busy       out  [CHANNELS]        channel in RUN
//   o_Done       out  [CHANNELS]        channel in DONE
//   o_DonePulse  out  [CHANNELS]        one-cycle strobe on entry to DONE
//   o_Tick       out  prescaler strobe
//   o_Seed       out  [WIDTH]           seed counter
//
// Build option: GAME_TIMER_SEED_EN
//   defined   - o_Seed is a free-running counter, +1 per cycle while
//               i_SeedRun=1, wrapping at 2^WIDTH.
//   undefined - no seed register; o_Seed is 0 and i_SeedRun is ignored.
// ---------------------------------------------------------------------------
module game_timer_bank
  import game_timer_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 2000,
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 2
) (
  input  logic                      clk_50M,
  input  logic                      i_Reset,
  input  logic [CHANNELS-1:0]       i_Start,
  input  logic [CHANNELS-1:0]       i_Zero,
  input  logic [CHANNELS*WIDTH-1:0] i_Limit,
  input  logic                      i_SeedRun,
  output logic [CHANNELS*WIDTH-1:0] o_Count,
  output logic [CHANNELS-1:0]       o_Busy,
  output logic [CHANNELS-1:0]       o_Done,
  output logic [CHANNELS-1:0]       o_DonePulse,
  output logic                      o_Tick,
  output logic [WIDTH-1:0]          o_Seed
);

  logic tick;

  tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_prescaler (
    .clk_50M (clk_50M),
    .i_Reset (i_Reset),
    .o_Tick  (tick)
  );

  assign o_Tick = tick;

  // -------------------------------------------------------------------------
  // Timer channels
  // -------------------------------------------------------------------------
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan

    timer_state_e     st_q, st_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             pulse_q, pulse_d;
    logic [WIDTH-1:0] lim_in;
    logic [WIDTH-1:0] cnt_inc;
    chan_dbg_t        dbg;
    logic             busy, done;

    assign lim_in  = i_Limit[c*WIDTH +: WIDTH];
    // Cannot overflow: in RUN the count is always below a nonzero limit.
    assign cnt_inc = cnt_q + 1'b1;

    // State register. The pulse is registered alongside the state so it
    // rises in the same cycle as o_Done.
    always_ff @(posedge clk_50M) begin
      if (i_Reset) begin
        st_q    <= IDLE;
        cnt_q   <= '0;
        lim_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        lim_q   <= lim_d;
        pulse_q <= pulse_d;
      end
    end

    // Next-state logic. Zero beats start, start beats the tick, so a start
    // landing on the cycle the count would reach the limit restarts the
    // channel and suppresses the pulse.
    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      lim_d   = lim_q;
      pulse_d = 1'b0;
      if (i_Zero[c]) begin
        st_d  = IDLE;
        cnt_d = '0;
      end else if (i_Start[c]) begin
        lim_d = lim_in;
        cnt_d = '0;
        if (lim_in == '0) begin
          // Zero limit: time out immediately.
          st_d    = DONE;
          pulse_d = 1'b1;
        end else begin
          st_d = RUN;
        end
      end else begin
        case (st_q)
          IDLE: st_d = IDLE;
          RUN: begin
            if (tick) begin
              cnt_d = cnt_inc;
              if (cnt_inc == lim_q) begin
                st_d    = DONE;
                pulse_d = 1'b1;
              end
            end
          end
          DONE: st_d = DONE;
          default: begin
            // Unreachable code 2'd3: recover to a clean IDLE.
            st_d  = IDLE;
            cnt_d = '0;
          end
        endcase
      end
    end

    // Observation record for this channel; the output decode reads it.
    assign dbg.state      = st_q;
    assign dbg.done_pulse = pulse_q;

    // Output decode, straight from registered state.
    always_comb begin
      busy = (dbg.state == RUN);
      done = (dbg.state == DONE);
    end

    assign o_Count[c*WIDTH +: WIDTH] = cnt_q;
    assign o_Busy[c]                 = busy;
    assign o_Done[c]                 = done;
    assign o_DonePulse[c]            = dbg.done_pulse;

  end : g_chan

  // -------------------------------------------------------------------------
  // Shuffle seed counter
  // -------------------------------------------------------------------------
`ifdef GAME_TIMER_SEED_EN
  logic [WIDTH-1:0] seed_q;

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      seed_q <= '0;
    end else if (i_SeedRun) begin
      seed_q <= seed_q + 1'b1;
    end
  end

  assign o_Seed = seed_q;
`else
  logic seed_run_unused;

  assign seed_run_unused = i_SeedRun;
  assign o_Seed          = '0;
`endif

endmodule

// File: tb/tb_game_timer_bank.sv
// ---------------------------------------------------------------------------
// tb_game_timer_bank
//
// Bench for game_timer_bank with CLK_HZ=10, TICK_HZ=1 (DIV=10), WIDTH=4,
// CHANNELS=2. Inputs change 1 time unit after a rising edge; outputs are
// sampled 1 time unit after the following rising edge.
//
// k is the index of the current cycle since reset release (cycle 0 is the
// first cycle with the prescaler at 0). o_Tick is expected when k%10 == 9.
// A timed channel started so that it is in RUN at cycle ks has counted
// floor(k/10) - floor(ks/10) ticks by cycle k, capped at its limit.
// ---------------------------------------------------------------------------
module tb_game_timer_bank;

  localparam int W   = 4;
  localparam int CH  = 2;
  localparam int DIV = 10;
  localparam int VW  = 19;

`ifdef GAME_TIMER_SEED_EN
  localparam bit             SEED_EN    = 1'b1;
  localparam logic [W-1:0]   SEED_FINAL = 4'd4;
`else
  localparam bit             SEED_EN    = 1'b0;
  localparam logic [W-1:0]   SEED_FINAL = 4'd0;
`endif

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  logic              i_Reset;
  logic [CH-1:0]     i_Start;
  logic [CH-1:0]     i_Zero;
  logic [CH*W-1:0]   i_Limit;
  logic              i_SeedRun;
  logic [CH*W-1:0]   o_Count;
  logic [CH-1:0]     o_Busy;
  logic [CH-1:0]     o_Done;
  logic [CH-1:0]     o_DonePulse;
  logic              o_Tick;
  logic [W-1:0]      o_Seed;

  game_timer_bank #(
    .CLK_HZ   (10),
    .TICK_HZ  (1),
    .WIDTH    (W),
    .CHANNELS (CH)
  ) dut (
    .clk_50M     (clk_50M),
    .i_Reset     (i_Reset),
    .i_Start     (i_Start),
    .i_Zero      (i_Zero),
    .i_Limit     (i_Limit),
    .i_SeedRun   (i_SeedRun),
    .o_Count     (o_Count),
    .o_Busy      (o_Busy),
    .o_Done      (o_Done),
    .o_DonePulse (o_DonePulse),
    .o_Tick      (o_Tick),
    .o_Seed      (o_Seed)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  logic [VW-1:0] exp_q[$];
  int            n_cmp  = 0;
  int            n_fail = 0;

  int            k = 0;
  bit            act [CH];
  int            ks  [CH];
  int            lim [CH];
  logic [W-1:0]  e_seed = '0;

  typedef struct {
    string         name;
    logic [CH-1:0] start;
    logic [CH-1:0] zero;
    logic [W-1:0]  lim0;
    logic [W-1:0]  lim1;
    logic [CH-1:0] e_busy;
    logic [CH-1:0] e_done;
    logic [CH-1:0] e_pulse;
    logic          e_tick;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [VW-1:0] pack(input logic [CH*W-1:0] cnt,
                                         input logic [CH-1:0] busy,
                                         input logic [CH-1:0] done,
                                         input logic [CH-1:0] pulse,
                                         input logic tick,
                                         input logic [W-1:0] seed);
    return {cnt, busy, done, pulse, tick, seed};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [CH*W-1:0] cnt;
    logic [CH-1:0]   busy, done, pulse;
    cnt   = '0;
    busy  = '0;
    done  = '0;
    pulse = '0;
    for (int c = 0; c < CH; c++) begin
      if (act[c]) begin
        int n;
        n = k / DIV - ks[c] / DIV;
        if (n >= lim[c]) begin
          cnt[c*W +: W] = W'(lim[c]);
          done[c]       = 1'b1;
          pulse[c]      = (k == ks[c]) || (((k - 1) / DIV - ks[c] / DIV) < lim[c]);
        end else begin
          cnt[c*W +: W] = W'(n);
          busy[c]       = 1'b1;
        end
      end
    end
    return pack(cnt, busy, done, pulse, (k % DIV) == DIV - 1, e_seed);
  endfunction

  task automatic check(input string name);
    logic [VW-1:0] got, exp;
    got = pack(o_Count, o_Busy, o_Done, o_DonePulse, o_Tick, o_Seed);
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected entry queued, got %h", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s @k=%0d: got %h required %h (cnt,busy,done,pulse,tick,seed)",
                 name, k, got, exp);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  // Apply the inputs currently on the pins for one edge, predict the result,
  // then compare.
  task automatic drive_cycle(input string name);
    for (int c = 0; c < CH; c++) begin
      if (i_Reset || i_Zero[c]) begin
        act[c] = 1'b0;
      end else if (i_Start[c]) begin
        act[c] = 1'b1;
        ks[c]  = k + 1;
        lim[c] = int'(i_Limit[c*W +: W]);
      end
    end
    if (i_Reset) begin
      k      = 0;
      e_seed = '0;
    end else begin
      k++;
      if (SEED_EN && i_SeedRun) e_seed = e_seed + 4'd1;
    end
    exp_q.push_back(model_vec());
    @(posedge clk_50M);
    #1;
    check(name);
  endtask

  task automatic idle_inputs();
    i_Start   = '0;
    i_Zero    = '0;
  endtask

  task automatic align();
    idle_inputs();
    while ((k % DIV) != DIV - 1) drive_cycle("align");
  endtask

  // -------------------------------------------------------------------------
  // Test
  // -------------------------------------------------------------------------
  initial begin
    tbl[0] = '{"start0_lim3",    2'b01, 2'b00, 4'd3, 4'd0, 2'b01, 2'b00, 2'b00, 1'b0};
    tbl[1] = '{"start1_lim0",    2'b10, 2'b00, 4'd3, 4'd0, 2'b01, 2'b10, 2'b10, 1'b0};
    tbl[2] = '{"done1_hold",     2'b00, 2'b00, 4'd3, 4'd0, 2'b01, 2'b10, 2'b00, 1'b0};
    tbl[3] = '{"zero_beats_st",  2'b10, 2'b10, 4'd3, 4'd7, 2'b01, 2'b00, 2'b00, 1'b0};
    tbl[4] = '{"st1_zero0",      2'b10, 2'b01, 4'd3, 4'd5, 2'b10, 2'b00, 2'b00, 1'b0};
    tbl[5] = '{"both_lim0",      2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 2'b11, 2'b11, 1'b0};
    tbl[6] = '{"zero0_done",     2'b00, 2'b01, 4'd0, 4'd0, 2'b00, 2'b10, 2'b00, 1'b0};
    tbl[7] = '{"lim1_ignored",   2'b01, 2'b00, 4'd9, 4'd3, 2'b01, 2'b10, 2'b00, 1'b0};
    tbl[8] = '{"zero_all_tick",  2'b00, 2'b11, 4'd9, 4'd3, 2'b00, 2'b00, 2'b00, 1'b1};

    for (int c = 0; c < CH; c++) begin
      act[c] = 1'b0;
      ks[c]  = 0;
      lim[c] = 0;
    end

    // Reset held 3 cycles: everything at 0.
    i_Reset   = 1'b1;
    i_Start   = '0;
    i_Zero    = '0;
    i_Limit   = '0;
    i_SeedRun = 1'b0;
    repeat (3) begin
      exp_q.push_back('0);
      @(posedge clk_50M);
      #1;
      check("reset");
    end
    i_Reset = 1'b0;
    k       = 0;

    // Single-edge effects, cycles 1..9 after release (no tick reaches a
    // channel before edge 10; the first tick is expected in cycle 9).
    for (int i = 0; i < 9; i++) begin
      i_Start = tbl[i].start;
      i_Zero  = tbl[i].zero;
      i_Limit = {tbl[i].lim1, tbl[i].lim0};
      exp_q.push_back(pack('0, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_pulse,
                           tbl[i].e_tick, 4'd0));
      k++;
      @(posedge clk_50M);
      #1;
      check(tbl[i].name);
    end
    idle_inputs();

    // Basic timeout: ch0 limit 3, counts 1,2,3 on successive ticks.
    align();
    i_Start = 2'b01;
    i_Limit = {4'd0, 4'd3};
    drive_cycle("basic_start");
    idle_inputs();
    repeat (31) drive_cycle("basic_run");

    // Restart with a smaller limit after two ticks.
    align();
    i_Start = 2'b01;
    i_Limit = {4'd0, 4'd5};
    drive_cycle("restart_first");
    idle_inputs();
    repeat (20) drive_cycle("restart_pre");
    i_Start = 2'b01;
    i_Limit = {4'd0, 4'd2};
    drive_cycle("restart_again");
    idle_inputs();
    repeat (22) drive_cycle("restart_run");

    // Maximum limit on ch0 alongside a short ch1; ch0 holds at 15.
    align();
    i_Start = 2'b11;
    i_Limit = {4'd1, 4'd15};
    drive_cycle("sat_start");
    idle_inputs();
    repeat (165) drive_cycle("sat_run");

    // Start on the very cycle ch0 would time out: restart wins, no pulse.
    align();
    i_Start = 2'b01;
    i_Limit = {4'd1, 4'd2};
    drive_cycle("race_start");
    idle_inputs();
    repeat (19) drive_cycle("race_run");
    i_Start = 2'b01;
    i_Limit = {4'd1, 4'd4};
    drive_cycle("race_restart");
    idle_inputs();
    repeat (12) drive_cycle("race_after");

    // Reset in the middle of a run: cleared, no pulse.
    i_Start = 2'b10;
    i_Limit = {4'd3, 4'd4};
    drive_cycle("rst_start");
    idle_inputs();
    repeat (12) drive_cycle("rst_run");
    i_Reset = 1'b1;
    drive_cycle("rst_mid_run");
    i_Reset = 1'b0;
    repeat (3) drive_cycle("rst_after");

    // Seed counter.
    i_SeedRun = 1'b1;
    repeat (20) drive_cycle("seed_run");
    n_cmp++;
    if (o_Seed !== SEED_FINAL) begin
      n_fail++;
      $display("FAIL seed_final: got %0d required %0d", o_Seed, SEED_FINAL);
    end
    i_SeedRun = 1'b0;
    repeat (3) drive_cycle("seed_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
